// File: rtl/log2_lut_axis.sv
// Fixed-point log2 for 32-bit signed samples: a leading-one detector gives the integer part and a log2(1+m) ROM gives the fraction; AXI-Stream on both sides.
// Optional macro LOG2_LUT_INTERP_EN adds a linear-interpolation stage that uses the mantissa bits below the table index.
module log2_lut_axis #(
  parameter int ADDR_BITS = 10,
  parameter int FRAC_BITS = 10,
  parameter int OUT_BITS = 16,
  parameter int INTERP_BITS = 6,
  parameter logic [OUT_BITS-1:0] NEG_CODE = 16'h8800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         tdata_in,
  input  logic                tvalid_in,
  input  logic                tlast_in,
  output logic                tready_in,
  output logic [OUT_BITS-1:0] tdata_out,
  output logic                tuser_out,
  output logic                tlast_out,
  output logic                tvalid_out,
  input  logic                tready_out
);

  localparam int DEPTH = (1 << ADDR_BITS) + 1;
  localparam int TW = FRAC_BITS + 1;
  localparam int TP = 56;
  localparam int TNB = FRAC_BITS + 12;

  if (ADDR_BITS + INTERP_BITS > 30 || OUT_BITS < FRAC_BITS + 6) begin : g_bad_params
    $error("log2_lut_axis: unsupported parameter combination");
  end

  // Elaboration-time log2(1+idx/2**ADDR_BITS) by repeated squaring, rounded to FRAC_BITS
  function automatic logic [FRAC_BITS:0] log2_entry(input int idx);
    logic [127:0] x;
    logic [31:0]  acc;
    x = 128'(idx + (1 << ADDR_BITS)) << (TP - ADDR_BITS);
    acc = '0;
    for (int k = 0; k < TNB; k++) begin
      x = (x * x) >> TP;
      acc = {acc[30:0], 1'b0};
      if (x >= (128'd2 << TP)) begin
        acc[0] = 1'b1;
        x = x >> 1;
      end
    end
    if (idx >= (1 << ADDR_BITS))
      log2_entry = TW'(1 << FRAC_BITS);
    else
      log2_entry = TW'((acc + (32'd1 << (TNB - FRAC_BITS - 1))) >> (TNB - FRAC_BITS));
  endfunction

  logic [FRAC_BITS:0] rom [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [FRAC_BITS:0] ENTRY = log2_entry(g);
    assign rom[g] = ENTRY;
  end

  logic en;
  assign en = !tvalid_out || tready_out;
  assign tready_in = en;

  logic [4:0]  msb_in;
  logic [29:0] below_in;
  logic        err_in;

  always_comb begin
    msb_in = '0;
    for (int i = 0; i < 31; i++)
      if (tdata_in[i]) msb_in = 5'(i);
  end

  // Shifting the leading one up to bit 30 and dropping it leaves the mantissa left-aligned, zero padded
  assign below_in = 30'(tdata_in[30:0] << (5'd30 - msb_in));
  assign err_in = tdata_in[31] || (tdata_in == 32'd0);

  logic                 v1, err1, last1;
  logic [4:0]           e1;
  logic [ADDR_BITS-1:0] a1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      err1 <= 1'b0;
      last1 <= 1'b0;
      e1 <= '0;
      a1 <= '0;
    end else if (en) begin
      v1 <= tvalid_in;
      err1 <= err_in;
      last1 <= tlast_in;
      e1 <= msb_in;
      a1 <= ADDR_BITS'(below_in >> (30 - ADDR_BITS));
    end
  end

  logic [ADDR_BITS:0] idx_lo;
  logic [TW-1:0]      t_lo;
  assign idx_lo = {1'b0, a1};

  always_ff @(posedge clk) begin
    if (en) t_lo <= rom[idx_lo];
  end

  logic       v2, err2, last2;
  logic [4:0] e2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      err2 <= 1'b0;
      last2 <= 1'b0;
      e2 <= '0;
    end else if (en) begin
      v2 <= v1;
      err2 <= err1;
      last2 <= last1;
      e2 <= e1;
    end
  end

  logic          v_fin, err_fin, last_fin;
  logic [4:0]    e_fin;
  logic [TW-1:0] y_fin;

`ifdef LOG2_LUT_INTERP_EN
  logic [INTERP_BITS-1:0]    f1, f2;
  logic [ADDR_BITS:0]        idx_hi;
  logic [TW-1:0]             t_hi, y3;
  logic [TW+INTERP_BITS-1:0] prod;
  logic                      v3, err3, last3;
  logic [4:0]                e3;

  assign idx_hi = idx_lo + (ADDR_BITS+1)'(1);
  always_ff @(posedge clk) begin
    if (en) t_hi <= rom[idx_hi];
  end

  // Table is monotonic, so the slope is never negative
  assign prod = (TW+INTERP_BITS)'(t_hi - t_lo) * (TW+INTERP_BITS)'(f2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f1 <= '0;
      f2 <= '0;
      v3 <= 1'b0;
      err3 <= 1'b0;
      last3 <= 1'b0;
      e3 <= '0;
      y3 <= '0;
    end else if (en) begin
      f1 <= INTERP_BITS'(below_in >> (30 - ADDR_BITS - INTERP_BITS));
      f2 <= f1;
      v3 <= v2;
      err3 <= err2;
      last3 <= last2;
      e3 <= e2;
      y3 <= t_lo + TW'(prod >> INTERP_BITS);
    end
  end

  assign v_fin = v3;
  assign err_fin = err3;
  assign last_fin = last3;
  assign e_fin = e3;
  assign y_fin = y3;
`else
  assign v_fin = v2;
  assign err_fin = err2;
  assign last_fin = last2;
  assign e_fin = e2;
  assign y_fin = t_lo;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid_out <= 1'b0;
      tdata_out <= '0;
      tuser_out <= 1'b0;
      tlast_out <= 1'b0;
    end else if (en) begin
      tvalid_out <= v_fin;
      tuser_out <= err_fin;
      tlast_out <= last_fin;
      tdata_out <= err_fin ? NEG_CODE
                           : (OUT_BITS'(e_fin) << FRAC_BITS) + OUT_BITS'(y_fin);
    end
  end

endmodule

// File: tb/tb_log2_lut_axis.sv
// Scoreboard bench for log2_lut_axis: directed vectors, random samples, a backpressure burst and reset mid-stream.
module tb_log2_lut_axis;

  localparam int ADDR_BITS = 10;
  localparam int FRAC_BITS = 10;
  localparam int INTERP_BITS = 6;
  localparam int MANT_BITS = ADDR_BITS + INTERP_BITS;
`ifdef LOG2_LUT_INTERP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata_in;
  logic        tvalid_in, tlast_in, tready_in;
  logic [15:0] tdata_out;
  logic        tuser_out, tlast_out, tvalid_out, tready_out;

  typedef struct packed {
    logic [15:0] data;
    logic        user;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t head;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  log2_lut_axis dut (
    .clk(clk), .rst(rst),
    .tdata_in(tdata_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in), .tready_in(tready_in),
    .tdata_out(tdata_out), .tuser_out(tuser_out), .tlast_out(tlast_out),
    .tvalid_out(tvalid_out), .tready_out(tready_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic int tbl(input int i);
    real v;
    v = $ln(1.0 + real'(i) / real'(1 << ADDR_BITS)) / $ln(2.0) * real'(1 << FRAC_BITS);
    return int'($floor(v + 0.5));
  endfunction

  function automatic exp_t model(input logic [31:0] d, input logic l);
    exp_t   r;
    int     e, mant, a, y;
    longint m;
    r.last = l;
    if (d[31] || d == 32'd0) begin
      r.data = 16'h8800;
      r.user = 1'b1;
    end else begin
      e = 0;
      for (int i = 0; i < 31; i++) if (d[i]) e = i;
      m = longint'(d) - (longint'(1) << e);
      if (e >= MANT_BITS) mant = int'(m >> (e - MANT_BITS));
      else mant = int'(m << (MANT_BITS - e));
      a = mant >> INTERP_BITS;
      y = tbl(a);
`ifdef LOG2_LUT_INTERP_EN
      y = y + (((tbl(a + 1) - tbl(a)) * (mant & ((1 << INTERP_BITS) - 1))) >> INTERP_BITS);
`endif
      r.data = 16'(e * (1 << FRAC_BITS) + y);
      r.user = 1'b0;
    end
    return r;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input exp_t want);
    int  guard = 0;
    bit  done = 0;
    tdata_in = d;
    tlast_in = l;
    tvalid_in = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (tready_in) begin
        sb.push_back(want);
        acc_cyc = cyc;
        done = 1;
      end else begin
        guard++;
        if (guard > 100) begin
          check("accept_timeout", 32'(tready_in), 32'd1);
          done = 1;
        end
      end
      sync();
    end
  endtask

  task automatic sendm(input logic [31:0] d, input logic l);
    send(d, l, model(d, l));
  endtask

  task automatic idle();
    tvalid_in = 1'b0;
    tlast_in = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || tvalid_out) && g < 100) begin
      sync();
      g++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output side: every transfer pops the scoreboard; while stalled the held word must be the head
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid_out && !tready_out) begin
        check("ready_in_stall", 32'(tready_in), 32'd0);
        if (sb.size() != 0) check("stall_data", 32'(tdata_out), 32'(sb[0].data));
      end
      if (tvalid_out && tready_out) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(tvalid_out), 32'd0);
        end else begin
          head = sb.pop_front();
          check("data", 32'(tdata_out), 32'(head.data));
          check("user", 32'(tuser_out), 32'(head.user));
          check("last", 32'(tlast_out), 32'(head.last));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    tdata_in = '0;
    tvalid_in = 1'b0;
    tlast_in = 1'b0;
    tready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid_out), 32'd0);
    check("rst_tdata", 32'(tdata_out), 32'd0);
    check("rst_tuser", 32'(tuser_out), 32'd0);
    check("rst_tlast", 32'(tlast_out), 32'd0);
    rst = 1'b0;
    sync();

    send(32'd1, 1'b0, '{16'h0000, 1'b0, 1'b0});
    idle();
    begin
      int g = 0;
      while (!tvalid_out && g < 20) begin
        @(negedge clk);
        g++;
      end
      check("latency", 32'(cyc - acc_cyc), 32'(LAT));
    end
    sync();
    drain();

    send(32'd1024, 1'b0, '{16'h2800, 1'b0, 1'b0});
    send(32'd3, 1'b0, '{16'h0657, 1'b0, 1'b0});
    send(32'd0, 1'b0, '{16'h8800, 1'b1, 1'b0});
    send(32'hFFFFFFFF, 1'b1, '{16'h8800, 1'b1, 1'b1});
    send(32'h7FFFFFFF, 1'b0, '{16'h7BFF, 1'b0, 1'b0});
    send(32'h80000000, 1'b1, '{16'h8800, 1'b1, 1'b1});
    send(32'd2, 1'b0, '{16'h0400, 1'b0, 1'b0});
    sendm(32'h00018020, 1'b1);
    sendm(32'h00000C20, 1'b0);
    idle();
    drain();

    for (int i = 0; i < 6; i++) sendm(32'($urandom), 1'($urandom_range(0, 1)));
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) sendm(32'(100 + i * 37), logic'(i == 7));
        idle();
      end
      begin
        sync();
        sync();
        tready_out = 1'b0;
        repeat (5) sync();
        tready_out = 1'b1;
      end
    join
    drain();

    sendm(32'd5, 1'b0);
    sendm(32'd6, 1'b0);
    sendm(32'd7, 1'b1);
    idle();
    rst = 1'b1;
    #1;
    check("tvalid_in_reset", 32'(tvalid_out), 32'd0);
    sb.delete();
    sync();
    sync();
    rst = 1'b0;
    sync();
    sendm(32'd9, 1'b1);
    idle();
    drain();
    repeat (6) sync();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
